// File: rtl/axi_stream_pkg.sv
// Shared types for the AXI-stream master/slave pair: default width, packet FSM
// states and the 4-bit saturating length type.
package axi_stream_pkg;

    localparam int DATA_W_DEFAULT = 256;
    localparam int LEN_W          = 4;

    typedef logic [LEN_W-1:0] len_t;

    localparam len_t LEN_MAX = len_t'((1 << LEN_W) - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } pkt_state_e;

    function automatic len_t satInc(input len_t value);
        return (value == LEN_MAX) ? value : value + len_t'(1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; the head word reads as zero
// whenever the FIFO is empty.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [CW-1:0]    count_q;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign rdata_o = empty_o ? '0 : mem_q[rdPtr_q];

    // Storage carries no reset; the empty gating above hides stale words.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/axi_stream_slave.sv
// AXI-stream receiver: buffers beats in a small FIFO and reports per-packet
// length, length errors and a running packet count from the input side.
module axi_stream_slave
    import axi_stream_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    output logic              s_tready,
    input  len_t              packet_size,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              pkt_done,
    output len_t              pkt_len,
    output logic              len_err,
    output logic [7:0]        pkt_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic             fifoFull;
    logic             fifoEmpty;
    logic [CNT_W-1:0] fifoCount;
    logic [DATA_W:0]  fifoRdata;
    logic             beatAccept;

    pkt_state_e state_q, state_d;
    len_t       beatCnt_q, beatCnt_d;
    len_t       pktLen_q, pktLen_d;
    logic       lenErr_q, lenErr_d;
    logic       pktDone_q, pktDone_d;
    logic [7:0] pktCount_q, pktCount_d;
    len_t       beatBase;
    len_t       beatNext;

    // Ready depends only on occupancy at cycle start, so a full FIFO never
    // accepts even when the consumer pops in the same cycle.
    assign s_tready   = !fifoFull && !rst;
    assign beatAccept = s_tvalid && s_tready;
    assign m_valid    = !fifoEmpty;
    assign {m_last, m_data} = fifoRdata;

    sync_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (beatAccept),
        .wdata_i ({s_tlast, s_tdata}),
        .pop_i   (m_valid && m_ready),
        .rdata_o (fifoRdata),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (fifoCount)
    );

    occupancyBound: assert property (@(posedge clk) disable iff (rst)
        fifoCount <= CNT_W'(FIFO_DEPTH));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (beatAccept && !s_tlast) state_d = IN_PKT;
            IN_PKT:  if (beatAccept && s_tlast)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A saturated count never equals a requested size below 15, so a single
    // inequality also covers over-long packets; size 0 disables the check.
    always_comb begin
        beatBase   = (state_q == IN_PKT) ? beatCnt_q : '0;
        beatNext   = satInc(beatBase);
        beatCnt_d  = beatCnt_q;
        pktLen_d   = pktLen_q;
        lenErr_d   = lenErr_q;
        pktCount_d = pktCount_q;
        pktDone_d  = 1'b0;
        if (beatAccept) begin
            beatCnt_d = beatNext;
            if (s_tlast) begin
                beatCnt_d  = '0;
                pktDone_d  = 1'b1;
                pktLen_d   = beatNext;
                lenErr_d   = (packet_size != '0) && (beatNext != packet_size);
                pktCount_d = pktCount_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beatCnt_q  <= '0;
            pktLen_q   <= '0;
            lenErr_q   <= 1'b0;
            pktDone_q  <= 1'b0;
            pktCount_q <= '0;
        end else begin
            beatCnt_q  <= beatCnt_d;
            pktLen_q   <= pktLen_d;
            lenErr_q   <= lenErr_d;
            pktDone_q  <= pktDone_d;
            pktCount_q <= pktCount_d;
        end
    end

    assign pkt_done  = pktDone_q;
    assign pkt_len   = pktLen_q;
    assign len_err   = lenErr_q;
    assign pkt_count = pktCount_q;

endmodule
